// File: rtl/ship_life_ctrl.sv
// Player-ship life-cycle sequencer: shared move/button tick generation, spawn/invulnerable/alive/
// explode/respawn/game-over FSM, and gating of thrust, visibility and collision response.
module ship_life_ctrl #(
    parameter int CLK_RATE      = 25_000_000,
    parameter int DIVIDER       = 125_000,
    parameter int BTN_RATE      = 10,
    parameter int LIVES         = 3,
    parameter int EXPLODE_TICKS = 100,
    parameter int RESPAWN_TICKS = 200,
    parameter int INVULN_TICKS  = 400,
    parameter int BLINK_TICKS   = 20,
    localparam int LIVES_W      = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic               collision,
    input  logic               thrust_btn,
    output logic               move_tick,
    output logic               btn_tick,
    output logic               ship_reinit,
    output logic               thrust_en,
    output logic               ship_visible,
    output logic               exploding,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic [2:0]         state_dbg
);

    localparam int BTN_DIV_RAW = CLK_RATE / DIVIDER / BTN_RATE;
    localparam int BTN_DIV     = (BTN_DIV_RAW < 1) ? 1 : BTN_DIV_RAW;
    localparam int TCW         = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int BCW         = (BTN_DIV > 1) ? $clog2(BTN_DIV) : 1;
    localparam int BLW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int MAXT_A      = (EXPLODE_TICKS > RESPAWN_TICKS) ? EXPLODE_TICKS : RESPAWN_TICKS;
    localparam int MAXT        = (MAXT_A > INVULN_TICKS) ? MAXT_A : INVULN_TICKS;
    localparam int TW          = $clog2(MAXT + 1);

    localparam logic [TCW-1:0]     TICK_LAST  = TCW'(DIVIDER - 1);
    localparam logic [BCW-1:0]     BTN_LAST   = BCW'(BTN_DIV - 1);
    localparam logic [BLW-1:0]     BLINK_LOAD = BLW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0]      EXP_LOAD   = TW'(EXPLODE_TICKS - 1);
    localparam logic [TW-1:0]      RESP_LOAD  = TW'(RESPAWN_TICKS - 1);
    localparam logic [TW-1:0]      INV_LOAD   = TW'(INVULN_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_INVULN    = 3'd2,
        S_ALIVE     = 3'd3,
        S_EXPLODE   = 3'd4,
        S_WAIT      = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [TCW-1:0]       tick_cnt_q;
    logic                 move_tick_q;
    logic [BCW-1:0]       btn_cnt_q;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BLW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                 blink_vis_q, blink_vis_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;

    // Free-running tick generation, independent of the FSM state.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            tick_cnt_q  <= '0;
            move_tick_q <= 1'b0;
            btn_cnt_q   <= '0;
        end else begin
            move_tick_q <= (tick_cnt_q == TICK_LAST);
            tick_cnt_q  <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TCW'(1);
            if (move_tick_q) begin
                btn_cnt_q <= (btn_cnt_q == BTN_LAST) ? '0 : btn_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b0;
            lives_q     <= LIVES_INIT;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            lives_q     <= lives_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        lives_d     = lives_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                state_d     = S_INVULN;
                timer_d     = INV_LOAD;
                blink_cnt_d = BLINK_LOAD;
                blink_vis_d = 1'b1;
            end
            S_INVULN: begin
                if (move_tick_q) begin
                    if (blink_cnt_q == '0) begin
                        blink_vis_d = ~blink_vis_q;
                        blink_cnt_d = BLINK_LOAD;
                    end else begin
                        blink_cnt_d = blink_cnt_q - BLW'(1);
                    end
                    if (timer_q == '0) state_d = S_ALIVE;
                    else               timer_d = timer_q - TW'(1);
                end
            end
            S_ALIVE: begin
                if (collision) begin
                    state_d = S_EXPLODE;
                    timer_d = EXP_LOAD;
                    if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
                end
            end
            S_EXPLODE: begin
                if (move_tick_q) begin
                    if (timer_q == '0) begin
                        if (lives_q == '0) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            state_d = S_WAIT;
                            timer_d = RESP_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (move_tick_q) begin
                    if (timer_q == '0) state_d = S_SPAWN;
                    else               timer_d = timer_q - TW'(1);
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    lives_d = LIVES_INIT;
                    state_d = S_SPAWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs from registered state; thrust gating is the only combinational path.
    assign move_tick    = move_tick_q;
    assign btn_tick     = move_tick_q && (btn_cnt_q == BTN_LAST);
    assign ship_reinit  = (state_q == S_SPAWN);
    assign thrust_en    = thrust_btn && ((state_q == S_INVULN) || (state_q == S_ALIVE));
    assign ship_visible = (state_q == S_ALIVE) || ((state_q == S_INVULN) && blink_vis_q);
    assign exploding    = (state_q == S_EXPLODE);
    assign game_over    = (state_q == S_GAME_OVER);
    assign lives        = lives_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ship_life_ctrl.sv
// Scoreboard bench for ship_life_ctrl: a behavioural model queues the expected output vector per
// clock, and the vector the DUT shows after that edge is popped and compared.
module tb_ship_life_ctrl;

    localparam int DIV  = 4;
    localparam int CLKR = 400;
    localparam int BR   = 10;
    localparam int NL   = 2;
    localparam int NE   = 3;
    localparam int NR   = 2;
    localparam int NI   = 4;
    localparam int NB   = 1;
    localparam int BDIV = CLKR / DIV / BR;

    localparam int ST_IDLE = 0, ST_SPAWN = 1, ST_INVULN = 2, ST_ALIVE = 3;
    localparam int ST_EXPLODE = 4, ST_WAIT = 5, ST_GO = 6;

    logic       clk = 1'b0;
    logic       resetN, start, collision, thrust_btn;
    logic       move_tick, btn_tick, ship_reinit, thrust_en, ship_visible, exploding, game_over;
    logic [1:0] lives;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    ship_life_ctrl #(
        .CLK_RATE(CLKR), .DIVIDER(DIV), .BTN_RATE(BR), .LIVES(NL),
        .EXPLODE_TICKS(NE), .RESPAWN_TICKS(NR), .INVULN_TICKS(NI), .BLINK_TICKS(NB)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start), .collision(collision), .thrust_btn(thrust_btn),
        .move_tick(move_tick), .btn_tick(btn_tick), .ship_reinit(ship_reinit), .thrust_en(thrust_en),
        .ship_visible(ship_visible), .exploding(exploding), .lives(lives), .game_over(game_over),
        .state_dbg(state_dbg)
    );

    wire [11:0] dut_vec = {move_tick, btn_tick, ship_reinit, thrust_en, ship_visible,
                           exploding, game_over, lives, state_dbg};

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int mt_seen = 0;
    int bt_seen = 0;

    int m_state, m_k, m_rem, m_lives, m_inv;
    bit m_mt, m_bt;
    logic [11:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] mdl_vec();
        logic vis, thr;
        logic [1:0] lv;
        logic [2:0] st;
        vis = (m_state == ST_ALIVE) || ((m_state == ST_INVULN) && (((m_inv / NB) % 2) == 0));
        thr = thrust_btn && ((m_state == ST_INVULN) || (m_state == ST_ALIVE));
        lv  = 2'(m_lives);
        st  = 3'(m_state);
        return {m_mt, m_bt, (m_state == ST_SPAWN), thr, vis, (m_state == ST_EXPLODE),
                (m_state == ST_GO), lv, st};
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic mdl_edge();
        bit mt;
        if (!resetN) begin
            m_state = ST_IDLE; m_k = 0; m_mt = 0; m_bt = 0;
            m_lives = NL; m_rem = 0; m_inv = 0;
        end else begin
            mt = m_mt;
            case (m_state)
                ST_IDLE:   if (start) m_state = ST_SPAWN;
                ST_SPAWN:  begin m_state = ST_INVULN; m_rem = NI; m_inv = 0; end
                ST_INVULN: if (mt) begin
                    m_inv++; m_rem--;
                    if (m_rem == 0) m_state = ST_ALIVE;
                end
                ST_ALIVE:  if (collision) begin
                    m_state = ST_EXPLODE; m_rem = NE;
                    if (m_lives > 0) m_lives--;
                end
                ST_EXPLODE: if (mt) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (m_lives == 0) m_state = ST_GO;
                        else begin m_state = ST_WAIT; m_rem = NR; end
                    end
                end
                ST_WAIT: if (mt) begin
                    m_rem--;
                    if (m_rem == 0) m_state = ST_SPAWN;
                end
                ST_GO: if (start) begin m_lives = NL; m_state = ST_SPAWN; end
                default: m_state = ST_IDLE;
            endcase
            m_k++;
            m_mt = ((m_k % DIV) == 0);
            m_bt = ((m_k % (DIV * BDIV)) == 0);
        end
    endtask

    task automatic step();
        logic [11:0] e;
        mdl_edge();
        sb_q.push_back(mdl_vec());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("cyc%0d", cyc), dut_vec, e);
        if (move_tick === 1'b1) mt_seen++;
        if (btn_tick === 1'b1) bt_seen++;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_for(input int target, input int budget);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("reach_st%0d", target), state_dbg, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; start = 1'b0; collision = 1'b0; thrust_btn = 1'b0;
        @(negedge clk);
        run(3);
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_lives", lives, NL);

        // Tick cadence in IDLE: move_tick every 4 clks, btn_tick at 40 and 80.
        resetN = 1'b1;
        mt_seen = 0; bt_seen = 0;
        run(85);
        chk("mt_count", mt_seen, 21);
        chk("bt_count", bt_seen, 2);

        // Spawn, invulnerable with ignored collisions, then alive.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("reinit_on", ship_reinit, 1);
        collision = 1'b1;
        step();
        chk("reinit_off", ship_reinit, 0);
        run(2);
        chk("inv_ignore", state_dbg, ST_INVULN);
        collision = 1'b0;
        wait_for(ST_ALIVE, 60);
        chk("alive_vis", ship_visible, 1);

        // Collision while thrusting.
        thrust_btn = 1'b1;
        run(2);
        chk("thr_alive", thrust_en, 1);
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("expl_lives", lives, 1);
        chk("expl_flag", exploding, 1);
        chk("thr_expl", thrust_en, 0);
        thrust_btn = 1'b0;
        wait_for(ST_WAIT, 60);
        wait_for(ST_SPAWN, 60);
        chk("respawn_reinit", ship_reinit, 1);
        wait_for(ST_ALIVE, 60);

        // Last life lost, start ignored mid-explosion, then game over and restart.
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("last_life", lives, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ign", state_dbg, ST_EXPLODE);
        wait_for(ST_GO, 60);
        chk("go_flag", game_over, 1);
        run(3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_lives", lives, NL);
        chk("restart_reinit", ship_reinit, 1);
        wait_for(ST_ALIVE, 60);

        // Reset mid-explosion, then tick phase restarts from release.
        collision = 1'b1;
        step();
        collision = 1'b0;
        run(2);
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        chk("midrst_state", state_dbg, ST_IDLE);
        chk("midrst_lives", lives, NL);
        run(3);
        chk("mt_early", move_tick, 0);
        step();
        chk("mt_first", move_tick, 1);

        // Reset glitch between edges has no effect.
        start = 1'b1;
        step();
        start = 1'b0;
        #2 resetN = 1'b0;
        #2 resetN = 1'b1;
        step();
        chk("glitch_state", state_dbg, ST_INVULN);

        // Collision held through the end of invulnerability.
        collision = 1'b1;
        wait_for(ST_EXPLODE, 80);
        chk("held_lives", lives, 1);
        run(2);
        chk("held_once", lives, 1);
        collision = 1'b0;
        run(30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
